cost_acceptance_unit: RTL and testbench
=======================================

Name: cost_acceptance_unit

Overview:
- Sits directly downstream of the clause-count stage (popcount of the unsatisfied-clause vector). Consumes one cost value per proposed variable flip.
- Per cost, decides accept/reject using greedy-plus-noise (WalkSAT-style) and tracks current cost, best cost and iteration count.
- Signals done when the formula is satisfied (cost 0) or the iteration budget is exhausted.

Parameters:
- NUMBER_OF_CLAUSES, 4: clauses in the formula; maximum legal cost.
- MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX, 2: cost ports are [MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX:0] (W = 3 bits by default).
- MAX_ITERATIONS, 16: RUN-state decisions allowed before giving up. Must be ≥1.
- ITER_WIDTH, 5: iteration counter width. Must satisfy 2^ITER_WIDTH > MAX_ITERATIONS.
- RAND_WIDTH, 8: width of the random input.
- NOISE_THRESHOLD, 32: a worse move is accepted when in_random < NOISE_THRESHOLD.

Ports:
- in_clk, input, 1: general clock.
- in_reset, input, 1: reset, asynchronous, active-low.
- in_start, input, 1: one-cycle pulse; starts or restarts a search.
- in_cost_valid, input, 1: in_cost is valid this cycle.
- in_cost, input, W: unsatisfied-clause count of the proposed assignment.
- in_random, input, RAND_WIDTH: random sample, sampled at the handshake cycle.
- out_cost_ready, output, 1: unit can consume a cost.
- out_decision_valid, output, 1: one-cycle pulse; out_accept is valid.
- out_accept, output, 1: 1 = keep the flip, 0 = undo the flip. Meaningful only while out_decision_valid is high.
- out_best_update, output, 1: one-cycle pulse; out_best_cost decreased on this decision.
- out_current_cost, output, W: cost of the currently held assignment.
- out_best_cost, output, W: lowest cost accepted since start.
- out_iteration, output, ITER_WIDTH: RUN decisions made since start.
- out_done, output, 1: level; search finished.
- out_solved, output, 1: level; finished with cost 0.

Behaviour:
- Reset (in_reset = 0, asynchronous):
  - State IDLE.
  - All outputs 0, except out_current_cost and out_best_cost, which are all-ones.
  - Reset is legal mid-search and aborts the search; no decision pulse is emitted.
- Handshake: a cost is consumed on a rising edge with in_cost_valid & out_cost_ready.
  - in_cost is ignored while in_cost_valid = 0. Upstream drives 0 when disabled, so 0 alone means nothing.
- out_cost_ready = 1 in INIT and RUN, 0 in IDLE and DONE. One cost can be accepted per cycle (full throughput).
- Decision latency: registered outputs update on the handshake edge and are visible the following cycle. out_decision_valid is high for exactly one cycle per handshake.
- FSM:
  - IDLE: in_start → INIT.
  - INIT: on handshake, current = best = in_cost; out_accept = 1; out_best_update = 1; out_iteration stays 0. If in_cost == 0 → DONE with solved = 1, else → RUN.
  - RUN: on handshake, out_iteration += 1.
    - Accept if in_cost <= current (ties accept).
    - Otherwise accept if in_random < NOISE_THRESHOLD (unsigned compare).
    - Otherwise reject; current is unchanged.
    - On accept: current = in_cost. If in_cost < best, then best = in_cost and out_best_update = 1.
  - RUN exit: if an accepted in_cost == 0 → DONE, solved = 1. Else if the incremented iteration == MAX_ITERATIONS → DONE, solved = 0. If both hold on the same cycle, solved = 1.
  - DONE: out_done = 1, outputs held. in_start → INIT, which clears out_done, out_solved and out_iteration.
- in_start in INIT or RUN restarts the search: → INIT, counters cleared. A handshake in the same cycle is discarded and no decision pulse is issued (start has priority).
- A rejected cost of 0 cannot occur, because 0 <= current always accepts.
- in_cost > NUMBER_OF_CLAUSES is illegal. The bench asserts on it; the RTL processes it unmodified.
- All comparisons are unsigned and W bits wide. No saturation is needed because in_cost ≤ 2^W − 1.

Decomposition:
- Shared package:
  - state enum: IDLE, INIT, RUN, DONE (2-bit).
  - cost-width helper: W = MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX + 1.
  - reset-value constant for the cost registers (all-ones).
- Natural sub-module: move_acceptance_decider. Purely combinational.
  - Inputs: in_cost, current, best, in_random.
  - Outputs: accept, improves_best.
  - Keeps the FSM and registers in the top module.

Test Plan:
- Reset mid-RUN (current = 2, iteration = 3), assert in_reset = 0 → same cycle: done = 0, ready = 0, costs = 3'b111, iteration = 0. No decision pulse.
- Start, then costs 3, 2, 2 with random = 255 → accept, accept, accept (tie). current = 2, best = 2. best_update pulses on decisions 1 and 2 only. iteration = 2.
- Current = 2, cost 4: random = 10 → accept, current = 4, best stays 2. random = 32 → reject, current stays 2.
- Costs 3, 1, 0 back-to-back with valid held high → three consecutive decision pulses, done = 1, solved = 1, iteration = 2, ready = 0 on the following cycle.
- MAX_ITERATIONS = 16, first cost 3, then 16 costs of 4 with random = 255 → 16 rejects, done = 1, solved = 0, best = 3. Repeat with the 16th cost = 0 → solved = 1.
- in_start asserted together with a valid cost in RUN → no decision pulse, state INIT, iteration = 0. The next cost is treated as the initial load.

Source files
------------

// File: rtl/cost_acceptance_unit_pkg.sv
// Shared types and constants for the WalkSAT-style cost acceptance unit.
package cost_acceptance_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Cost ports carry a count up to the clause count, one bit wider than the index.
  function automatic int unsigned cost_width(input int unsigned max_clause_index_w);
    return max_clause_index_w + 1;
  endfunction

  // Cost registers come out of reset all-ones; truncate to the cost width at use.
  localparam logic [31:0] COST_RESET_ALL_ONES = '1;

endpackage

// File: rtl/cost_acceptance_unit_move_acceptance_decider.sv
// Combinational greedy-plus-noise accept decision for one proposed flip.
module move_acceptance_decider #(
  parameter int unsigned W               = 3,
  parameter int unsigned RAND_WIDTH      = 8,
  parameter int unsigned NOISE_THRESHOLD = 32
) (
  input  logic [W-1:0]          in_cost,
  input  logic [W-1:0]          in_current,
  input  logic [W-1:0]          in_best,
  input  logic [RAND_WIDTH-1:0] in_random,
  output logic                  out_accept,
  output logic                  out_improves_best
);

  logic greedy_ok;
  logic noise_ok;

  // Ties count as non-worsening; worse moves pass only on a low random draw.
  assign greedy_ok         = (in_cost <= in_current);
  assign noise_ok          = (32'(in_random) < NOISE_THRESHOLD);
  assign out_accept        = greedy_ok | noise_ok;
  assign out_improves_best = out_accept & (in_cost < in_best);

endmodule

// File: rtl/cost_acceptance_unit.sv
// Consumes one cost per proposed flip, decides accept/reject and tracks
// current cost, best cost and iteration count until solved or out of budget.
module cost_acceptance_unit
  import cost_acceptance_unit_pkg::*;
#(
  parameter int unsigned NUMBER_OF_CLAUSES                 = 4,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX = 2,
  parameter int unsigned MAX_ITERATIONS                    = 16,
  parameter int unsigned ITER_WIDTH                        = 5,
  parameter int unsigned RAND_WIDTH                        = 8,
  parameter int unsigned NOISE_THRESHOLD                   = 32
) (
  input  logic                                       in_clk,
  input  logic                                       in_reset,
  input  logic                                       in_start,
  input  logic                                       in_cost_valid,
  input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX:0] in_cost,
  input  logic [RAND_WIDTH-1:0]                      in_random,
  output logic                                       out_cost_ready,
  output logic                                       out_decision_valid,
  output logic                                       out_accept,
  output logic                                       out_best_update,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX:0] out_current_cost,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX:0] out_best_cost,
  output logic [ITER_WIDTH-1:0]                      out_iteration,
  output logic                                       out_done,
  output logic                                       out_solved
);

  localparam int unsigned W = cost_width(MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX);
  localparam logic [W-1:0] COST_RST = W'(COST_RESET_ALL_ONES);
  localparam logic [ITER_WIDTH-1:0] ITER_LAST = ITER_WIDTH'(MAX_ITERATIONS);

  // Elaboration-time parameter sanity.
  if (MAX_ITERATIONS < 1 || (2 ** ITER_WIDTH) <= MAX_ITERATIONS ||
      NUMBER_OF_CLAUSES >= (2 ** W)) begin : g_bad_params
    $error("cost_acceptance_unit: inconsistent parameters");
  end

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  dvalid_q, dvalid_d;
  logic                  accept_q, accept_d;
  logic                  best_upd_q, best_upd_d;
  logic [W-1:0]          current_q, current_d;
  logic [W-1:0]          best_q, best_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic                  done_q, done_d;
  logic                  solved_q, solved_d;

  logic handshake_c;
  logic dec_accept_c;
  logic dec_improves_c;

  assign handshake_c = in_cost_valid & ready_q;

  move_acceptance_decider #(
    .W               (W),
    .RAND_WIDTH      (RAND_WIDTH),
    .NOISE_THRESHOLD (NOISE_THRESHOLD)
  ) u_decider (
    .in_cost           (in_cost),
    .in_current        (current_q),
    .in_best           (best_q),
    .in_random         (in_random),
    .out_accept        (dec_accept_c),
    .out_improves_best (dec_improves_c)
  );

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      dvalid_q   <= 1'b0;
      accept_q   <= 1'b0;
      best_upd_q <= 1'b0;
      current_q  <= COST_RST;
      best_q     <= COST_RST;
      iter_q     <= '0;
      done_q     <= 1'b0;
      solved_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      dvalid_q   <= dvalid_d;
      accept_q   <= accept_d;
      best_upd_q <= best_upd_d;
      current_q  <= current_d;
      best_q     <= best_d;
      iter_q     <= iter_d;
      done_q     <= done_d;
      solved_q   <= solved_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dvalid_d   = 1'b0;
    accept_d   = accept_q;
    best_upd_d = 1'b0;
    current_d  = current_q;
    best_d     = best_q;
    iter_d     = iter_q;
    done_d     = done_q;
    solved_d   = solved_q;

    // Start wins over any same-cycle handshake; the cost is dropped.
    if (in_start) begin
      state_d  = INIT;
      iter_d   = '0;
      done_d   = 1'b0;
      solved_d = 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (handshake_c) begin
            dvalid_d   = 1'b1;
            accept_d   = 1'b1;
            best_upd_d = 1'b1;
            current_d  = in_cost;
            best_d     = in_cost;
            if (in_cost == '0) begin
              state_d  = DONE;
              done_d   = 1'b1;
              solved_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (handshake_c) begin
            dvalid_d = 1'b1;
            accept_d = dec_accept_c;
            iter_d   = iter_q + ITER_WIDTH'(1);
            if (dec_accept_c) begin
              current_d = in_cost;
            end
            if (dec_improves_c) begin
              best_d     = in_cost;
              best_upd_d = 1'b1;
            end
            // Solved takes precedence over budget exhaustion on the same decision.
            if (dec_accept_c && in_cost == '0) begin
              state_d  = DONE;
              done_d   = 1'b1;
              solved_d = 1'b1;
            end else if (iter_d == ITER_LAST) begin
              state_d  = DONE;
              done_d   = 1'b1;
              solved_d = 1'b0;
            end
          end
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d == INIT) || (state_d == RUN);
  end

  assign out_cost_ready     = ready_q;
  assign out_decision_valid = dvalid_q;
  assign out_accept         = accept_q;
  assign out_best_update    = best_upd_q;
  assign out_current_cost   = current_q;
  assign out_best_cost      = best_q;
  assign out_iteration      = iter_q;
  assign out_done           = done_q;
  assign out_solved         = solved_q;

endmodule

// File: tb/tb_cost_acceptance_unit.sv
// Directed, table-driven bench for cost_acceptance_unit with hand-computed expectations.
module tb_cost_acceptance_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cvalid;
  logic [2:0] cost;
  logic [7:0] rnd;
  logic       ready;
  logic       dvalid;
  logic       accept;
  logic       bupd;
  logic [2:0] cur;
  logic [2:0] best;
  logic [4:0] iter;
  logic       done;
  logic       solved;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic       start;
    logic       valid;
    logic [2:0] cost;
    logic [7:0] rnd;
    logic       e_valid;
    logic       e_acc;
    logic       e_bu;
    logic [2:0] e_cur;
    logic [2:0] e_best;
    logic [4:0] e_iter;
    logic       e_done;
    logic       e_solved;
    logic       e_ready;
  } vec_t;

  vec_t vq[$];

  cost_acceptance_unit dut (
    .in_clk             (clk),
    .in_reset           (rst_n),
    .in_start           (start),
    .in_cost_valid      (cvalid),
    .in_cost            (cost),
    .in_random          (rnd),
    .out_cost_ready     (ready),
    .out_decision_valid (dvalid),
    .out_accept         (accept),
    .out_best_update    (bupd),
    .out_current_cost   (cur),
    .out_best_cost      (best),
    .out_iteration      (iter),
    .out_done           (done),
    .out_solved         (solved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && cvalid) begin
      assert (cost <= 3'd4) else $error("illegal cost %0d driven", cost);
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic v, input logic [2:0] c, input logic [7:0] r,
                     input logic ev, input logic ea, input logic eb,
                     input logic [2:0] ec, input logic [2:0] ebst, input logic [4:0] ei,
                     input logic ed, input logic es, input logic er);
    vec_t t;
    t.start = s;  t.valid = v;  t.cost = c;  t.rnd = r;
    t.e_valid = ev; t.e_acc = ea; t.e_bu = eb;
    t.e_cur = ec; t.e_best = ebst; t.e_iter = ei;
    t.e_done = ed; t.e_solved = es; t.e_ready = er;
    vq.push_back(t);
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after it.
  task automatic drive(input logic s, input logic v, input logic [2:0] c, input logic [7:0] r);
    @(negedge clk);
    start = s; cvalid = v; cost = c; rnd = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input vec_t t);
    chk("decision_valid", idx, 32'(dvalid), 32'(t.e_valid));
    if (t.e_valid) chk("accept", idx, 32'(accept), 32'(t.e_acc));
    chk("best_update", idx, 32'(bupd), 32'(t.e_bu));
    chk("current_cost", idx, 32'(cur), 32'(t.e_cur));
    chk("best_cost", idx, 32'(best), 32'(t.e_best));
    chk("iteration", idx, 32'(iter), 32'(t.e_iter));
    chk("done", idx, 32'(done), 32'(t.e_done));
    chk("solved", idx, 32'(solved), 32'(t.e_solved));
    chk("ready", idx, 32'(ready), 32'(t.e_ready));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0; start = 1'b0; cvalid = 1'b0; cost = '0; rnd = '0;

    //   st  vl  cost   rnd      dv   acc  bu   cur   best  iter   done solv rdy
    add(1'b1,1'b0,3'd0,8'd0,   1'b0,1'b0,1'b0,3'd7,3'd7,5'd0,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd3,8'd255, 1'b1,1'b1,1'b1,3'd3,3'd3,5'd0,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd2,8'd255, 1'b1,1'b1,1'b1,3'd2,3'd2,5'd1,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd2,8'd255, 1'b1,1'b1,1'b0,3'd2,3'd2,5'd2,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd4,8'd10,  1'b1,1'b1,1'b0,3'd4,3'd2,5'd3,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd2,8'd255, 1'b1,1'b1,1'b0,3'd2,3'd2,5'd4,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd4,8'd32,  1'b1,1'b0,1'b0,3'd2,3'd2,5'd5,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd4,8'd31,  1'b1,1'b1,1'b0,3'd4,3'd2,5'd6,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd2,8'd255, 1'b1,1'b1,1'b0,3'd2,3'd2,5'd7,  1'b0,1'b0,1'b1);
    add(1'b0,1'b0,3'd0,8'd0,   1'b0,1'b0,1'b0,3'd2,3'd2,5'd7,  1'b0,1'b0,1'b1);
    add(1'b1,1'b1,3'd3,8'd255, 1'b0,1'b0,1'b0,3'd2,3'd2,5'd0,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd3,8'd255, 1'b1,1'b1,1'b1,3'd3,3'd3,5'd0,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd1,8'd255, 1'b1,1'b1,1'b1,3'd1,3'd1,5'd1,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd0,8'd255, 1'b1,1'b1,1'b1,3'd0,3'd0,5'd2,  1'b1,1'b1,1'b0);
    add(1'b0,1'b1,3'd2,8'd0,   1'b0,1'b0,1'b0,3'd0,3'd0,5'd2,  1'b1,1'b1,1'b0);
    add(1'b1,1'b0,3'd0,8'd0,   1'b0,1'b0,1'b0,3'd0,3'd0,5'd0,  1'b0,1'b0,1'b1);
    add(1'b0,1'b1,3'd0,8'd255, 1'b1,1'b1,1'b1,3'd0,3'd0,5'd0,  1'b1,1'b1,1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 0, 32'(ready), 32'd0);
    chk("reset_cur", 0, 32'(cur), 32'd7);
    chk("reset_best", 0, 32'(best), 32'd7);
    chk("reset_iter", 0, 32'(iter), 32'd0);
    chk("reset_done", 0, 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].valid, vq[i].cost, vq[i].rnd);
      check_all(i, vq[i]);
    end

    // Budget exhaustion: 16 worse costs all rejected.
    drive(1'b1, 1'b0, 3'd0, 8'd0);
    drive(1'b0, 1'b1, 3'd3, 8'd255);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b1, 3'd4, 8'd255);
      chk("exh_valid", k, 32'(dvalid), 32'd1);
      chk("exh_accept", k, 32'(accept), 32'd0);
      chk("exh_iter", k, 32'(iter), 32'(k));
      chk("exh_done", k, 32'(done), 32'(k == 16));
    end
    chk("exh_solved", 0, 32'(solved), 32'd0);
    chk("exh_best", 0, 32'(best), 32'd3);
    chk("exh_cur", 0, 32'(cur), 32'd3);
    chk("exh_ready", 0, 32'(ready), 32'd0);

    // Same again, but the final decision solves: solved wins.
    drive(1'b1, 1'b0, 3'd0, 8'd0);
    chk("restart_done", 0, 32'(done), 32'd0);
    drive(1'b0, 1'b1, 3'd3, 8'd255);
    for (int k = 1; k <= 15; k++) drive(1'b0, 1'b1, 3'd4, 8'd255);
    chk("exh2_iter15", 0, 32'(iter), 32'd15);
    chk("exh2_done15", 0, 32'(done), 32'd0);
    drive(1'b0, 1'b1, 3'd0, 8'd255);
    chk("exh2_accept", 0, 32'(accept), 32'd1);
    chk("exh2_bupd", 0, 32'(bupd), 32'd1);
    chk("exh2_iter", 0, 32'(iter), 32'd16);
    chk("exh2_done", 0, 32'(done), 32'd1);
    chk("exh2_solved", 0, 32'(solved), 32'd1);
    chk("exh2_best", 0, 32'(best), 32'd0);

    // Asynchronous reset in the middle of a run.
    drive(1'b1, 1'b0, 3'd0, 8'd0);
    drive(1'b0, 1'b1, 3'd3, 8'd255);
    drive(1'b0, 1'b1, 3'd2, 8'd255);
    drive(1'b0, 1'b1, 3'd2, 8'd255);
    drive(1'b0, 1'b1, 3'd2, 8'd255);
    chk("pre_rst_cur", 0, 32'(cur), 32'd2);
    chk("pre_rst_iter", 0, 32'(iter), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", 0, 32'(done), 32'd0);
    chk("mid_rst_ready", 0, 32'(ready), 32'd0);
    chk("mid_rst_cur", 0, 32'(cur), 32'd7);
    chk("mid_rst_best", 0, 32'(best), 32'd7);
    chk("mid_rst_iter", 0, 32'(iter), 32'd0);
    chk("mid_rst_dvalid", 0, 32'(dvalid), 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_dvalid", 0, 32'(dvalid), 32'd0);
    chk("held_rst_ready", 0, 32'(ready), 32'd0);
    @(negedge clk);
    cvalid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ready", 0, 32'(ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
